instruction_fetch: RTL and testbench

Fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the word address into the memory, captures the combinationally returned instruction into an IF/ID output register, and hands it to decode over a valid/ready handshake. It also supports stalls, branch/jump redirects with flush, and halting at end of program, signalled by the memory's Exit flag or by an out-of-range PC.

---
 rtl/instruction_fetch.sv | 75 +++++++
 tb/tb_instruction_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and IF/ID register with valid/ready handoff, redirect/flush and halt.
// Ports:
//   Clock, Reset_n                   rising-edge clock, async active-low reset
//   Instruction_Add                  word address to instruction memory (the PC)
//   Instruction, Exit                combinational memory read data and end-of-program flag
//   Redirect, Redirect_Target        taken branch/jump and its word-address target
//   Id_Ready                         decode accepts the held instruction this cycle
//   If_Valid, If_Instruction, If_Pc  IF/ID register contents
//   Halted                           fetch stopped at end of program
//   Fetch_Count                      instructions captured since reset
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_WORDS = 32
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic [31:0] Instruction_Add,
    input  logic [31:0] Instruction,
    input  logic        Exit,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Target,
    input  logic        Id_Ready,
    output logic        If_Valid,
    output logic [31:0] If_Instruction,
    output logic [31:0] If_Pc,
    output logic        Halted,
    output logic [31:0] Fetch_Count
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_d;
    logic [31:0] pc;
    logic        end_hit, slot_free, run, fire;

    assign Instruction_Add = pc;
    assign end_hit         = Exit | (pc >= 32'(MEM_WORDS));
    assign slot_free       = !If_Valid | Id_Ready;
    assign run             = state == RUN;
    assign fire            = run & !Redirect & !end_hit & slot_free;

    always_ff @(posedge Clock or negedge Reset_n)
        if (!Reset_n) state <= RUN;
        else          state <= state_d;

    always_comb
        state_d = Redirect                      ? RUN  :
                  (run & end_hit & slot_free)   ? HALT : state;

    always_comb
        Halted = state == HALT;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc             <= RESET_PC;
            If_Valid       <= 1'b0;
            If_Instruction <= '0;
            If_Pc          <= '0;
            Fetch_Count    <= '0;
        end else if (Redirect) begin
            pc       <= Redirect_Target;
            If_Valid <= 1'b0;
        end else if (run & end_hit) begin
            // with no free slot the halt decision waits and the held word stays put
            if (slot_free) If_Valid <= 1'b0;
        end else if (fire) begin
            If_Instruction <= Instruction;
            If_Pc          <= pc;
            If_Valid       <= 1'b1;
            pc             <= pc + 32'd1;
            Fetch_Count    <= Fetch_Count + 32'd1;
        end else if (If_Valid & Id_Ready) begin
            If_Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scoreboard bench for instruction_fetch.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] target;
    logic        id_ready;

    logic [31:0] add_a, instr_a, if_instr_a, if_pc_a, fc_a;
    logic        exit_a, if_valid_a, halted_a;
    logic [31:0] add_b, instr_b, if_instr_b, if_pc_b, fc_b;
    logic        if_valid_b, halted_b;

    logic [31:0] mem [0:63];
    logic        init [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;
    item_t sb [$];

    always #5 clk = ~clk;

    assign instr_a = (add_a < 32'd64) ? mem[add_a[5:0]] : 32'd0;
    assign exit_a  = (add_a < 32'd64) ? !init[add_a[5:0]] : 1'b1;
    assign instr_b = add_b ^ 32'hB000_0000;

    instruction_fetch #(.RESET_PC(32'd0), .MEM_WORDS(32)) dut_a (
        .Clock(clk), .Reset_n(rst_n), .Instruction_Add(add_a), .Instruction(instr_a),
        .Exit(exit_a), .Redirect(redirect), .Redirect_Target(target), .Id_Ready(id_ready),
        .If_Valid(if_valid_a), .If_Instruction(if_instr_a), .If_Pc(if_pc_a),
        .Halted(halted_a), .Fetch_Count(fc_a)
    );

    instruction_fetch #(.RESET_PC(32'd31), .MEM_WORDS(32)) dut_b (
        .Clock(clk), .Reset_n(rst_n), .Instruction_Add(add_b), .Instruction(instr_b),
        .Exit(1'b0), .Redirect(1'b0), .Redirect_Target(32'd0), .Id_Ready(id_ready),
        .If_Valid(if_valid_b), .If_Instruction(if_instr_b), .If_Pc(if_pc_b),
        .Halted(halted_b), .Fetch_Count(fc_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens on the next edge whenever If_Valid & Id_Ready mid-cycle
    always @(negedge clk) begin
        if (rst_n && if_valid_a && id_ready) begin
            item_t e;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h with empty scoreboard", if_pc_a);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", if_pc_a, e.pc);
                chk("sb_instr", if_instr_a, e.instr);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 32'hDEAD_0000;
            init[i] = 1'b0;
        end
        mem[0]  = 32'h0010_0093; init[0]  = 1'b1;
        mem[1]  = 32'h0020_0113; init[1]  = 1'b1;
        mem[2]  = 32'h0030_0193; init[2]  = 1'b1;
        mem[3]  = 32'h0040_0213; init[3]  = 1'b1;
        mem[10] = 32'h00A0_0513; init[10] = 1'b1;
        mem[11] = 32'h00B0_0593; init[11] = 1'b1;

        rst_n = 1'b0; redirect = 1'b0; target = 32'd0; id_ready = 1'b1;
        repeat (2) tick;
        chk("rst_valid", {31'd0, if_valid_a}, 32'd0);
        chk("rst_halted", {31'd0, halted_a}, 32'd0);
        chk("rst_add", add_a, 32'd0);
        chk("rst_fc", fc_a, 32'd0);
        chk("rst_if_pc", if_pc_a, 32'd0);
        chk("rst_if_instr", if_instr_a, 32'd0);
        chk("rst_add_b", add_b, 32'd31);

        // run 0..3 then halt on uninitialised word 4
        sb.push_back({32'd0, 32'h0010_0093});
        sb.push_back({32'd1, 32'h0020_0113});
        sb.push_back({32'd2, 32'h0030_0193});
        sb.push_back({32'd3, 32'h0040_0213});
        rst_n = 1'b1;
        tick;
        chk("run_pc0", if_pc_a, 32'd0);
        chk("oor_if_pc", if_pc_b, 32'd31);
        chk("oor_valid", {31'd0, if_valid_b}, 32'd1);
        chk("oor_instr", if_instr_b, 32'hB000_001F);
        tick;
        chk("oor_halted", {31'd0, halted_b}, 32'd1);
        chk("oor_add", add_b, 32'd32);
        chk("oor_valid_low", {31'd0, if_valid_b}, 32'd0);
        chk("oor_fc", fc_b, 32'd1);
        repeat (3) tick;
        chk("halt_halted", {31'd0, halted_a}, 32'd1);
        chk("halt_valid", {31'd0, if_valid_a}, 32'd0);
        chk("halt_add", add_a, 32'd4);
        chk("halt_fc", fc_a, 32'd4);
        tick;
        chk("halt_add_hold", add_a, 32'd4);
        chk("halt_stays", {31'd0, halted_a}, 32'd1);

        // redirect out of HALT to 1, then stall on If_Pc = 1
        id_ready = 1'b0; redirect = 1'b1; target = 32'd1;
        tick;
        chk("rdh_halted", {31'd0, halted_a}, 32'd0);
        chk("rdh_add", add_a, 32'd1);
        chk("rdh_valid", {31'd0, if_valid_a}, 32'd0);
        chk("rdh_fc", fc_a, 32'd4);
        redirect = 1'b0;
        tick;
        chk("rdh_if_pc", if_pc_a, 32'd1);
        chk("rdh_if_valid", {31'd0, if_valid_a}, 32'd1);
        chk("rdh_fc2", fc_a, 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_if_pc", if_pc_a, 32'd1);
            chk("stall_instr", if_instr_a, 32'h0020_0113);
            chk("stall_add", add_a, 32'd2);
            chk("stall_valid", {31'd0, if_valid_a}, 32'd1);
        end
        sb.push_back({32'd1, 32'h0020_0113});
        id_ready = 1'b1;
        tick;
        id_ready = 1'b0;
        chk("unstall_if_pc", if_pc_a, 32'd2);
        chk("unstall_fc", fc_a, 32'd6);

        // redirect with flush while If_Pc = 2 is held
        redirect = 1'b1; target = 32'd10;
        tick;
        chk("flush_valid", {31'd0, if_valid_a}, 32'd0);
        chk("flush_add", add_a, 32'd10);
        chk("flush_fc", fc_a, 32'd6);
        redirect = 1'b0; id_ready = 1'b1;
        sb.push_back({32'd10, 32'h00A0_0513});
        sb.push_back({32'd11, 32'h00B0_0593});
        tick;
        chk("tgt_if_pc", if_pc_a, 32'd10);
        chk("tgt_valid", {31'd0, if_valid_a}, 32'd1);
        chk("tgt_fc", fc_a, 32'd7);
        tick;
        chk("tgt_add", add_a, 32'd12);
        tick;
        chk("end2_halted", {31'd0, halted_a}, 32'd1);
        chk("end2_fc", fc_a, 32'd8);

        // async reset mid-stall
        id_ready = 1'b0; redirect = 1'b1; target = 32'd2;
        tick;
        redirect = 1'b0;
        tick;
        chk("pre_rst_valid", {31'd0, if_valid_a}, 32'd1);
        chk("pre_rst_add", add_a, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid_a}, 32'd0);
        chk("arst_add", add_a, 32'd0);
        chk("arst_fc", fc_a, 32'd0);
        chk("arst_halted", {31'd0, halted_a}, 32'd0);
        chk("arst_add_b", add_b, 32'd31);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
